// File: rtl/drive_mode_arbiter.sv
// Drive-mode arbiter: grants one of three motion controllers access to the drive
// stage and inserts a fixed drain/settle window whenever the granted mode changes.
//
//   state   | meaning
//   S_OFF   | powered down, no grants, drive stage idle
//   S_RUN   | active_mode controller granted, its motion vector forwarded
//   S_DRAIN | mode change in progress, everything held at zero for SETTLE_CYC cycles
module drive_mode_arbiter #(
  parameter int unsigned SETTLE_CYC = 32'd100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_btn,
  input  logic       mode_req,
  input  logic [1:0] mode_sel,
  input  logic [3:0] man_mv,
  input  logic [3:0] semi_mv,
  input  logic [3:0] auto_mv,
  output logic       manual_enable,
  output logic       semi_auto_enable,
  output logic       auto_enable,
  output logic [3:0] mv_out,
  output logic [1:0] active_mode,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10
  } state_t;

  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);

  state_t      state;
  logic        pwr_q;
  logic        mode_q;
  logic        pwr_armed;
  logic [1:0]  pending_mode;
  logic [31:0] cnt;

  logic        pwr_edge;
  logic        mode_edge;
  logic        mode_ok;
  logic [3:0]  sel_mv;
  logic [3:0]  clean_mv;

  // pwr_armed blocks a button already held high across reset release from
  // being taken as a fresh press.
  always_comb begin
    pwr_edge  = power_btn & ~pwr_q & pwr_armed;
    mode_edge = mode_req & ~mode_q;
    mode_ok   = (mode_sel != 2'b11) && (mode_sel != active_mode);
  end

  always_comb begin
    sel_mv = 4'b0000;
    case (active_mode)
      2'b00:   sel_mv = man_mv;
      2'b01:   sel_mv = semi_mv;
      2'b10:   sel_mv = auto_mv;
      default: sel_mv = 4'b0000;
    endcase
    // Contradictory axis requests cancel out rather than picking a winner.
    clean_mv = sel_mv & ~{{2{&sel_mv[3:2]}}, {2{&sel_mv[1:0]}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_OFF;
      pwr_q        <= 1'b0;
      mode_q       <= 1'b0;
      pwr_armed    <= 1'b0;
      pending_mode <= 2'b00;
      active_mode  <= 2'b00;
      cnt          <= 32'd0;
      mv_out       <= 4'b0000;
      err          <= 1'b0;
    end else begin
      pwr_q  <= power_btn;
      mode_q <= mode_req;
      if (!power_btn) pwr_armed <= 1'b1;

      mv_out <= 4'b0000;
      err    <= 1'b0;

      case (state)
        S_OFF: begin
          if (pwr_edge) begin
            state       <= S_RUN;
            active_mode <= 2'b00;
          end
        end
        S_RUN: begin
          if (pwr_edge) begin
            state <= S_OFF;
          end else if (mode_edge && mode_ok) begin
            state        <= S_DRAIN;
            pending_mode <= mode_sel;
            cnt          <= 32'd0;
          end else begin
            mv_out <= clean_mv;
            err    <= mode_edge && (mode_sel == 2'b11);
          end
        end
        S_DRAIN: begin
          if (pwr_edge) begin
            state <= S_OFF;
          end else begin
            err <= mode_edge;
            cnt <= cnt + 32'd1;
            if (cnt == SETTLE_LAST) begin
              state       <= S_RUN;
              active_mode <= pending_mode;
            end
          end
        end
        default: state <= S_OFF;
      endcase
    end
  end

  assign manual_enable    = (state == S_RUN) && (active_mode == 2'b00);
  assign semi_auto_enable = (state == S_RUN) && (active_mode == 2'b01);
  assign auto_enable      = (state == S_RUN) && (active_mode == 2'b10);
  assign busy             = (state == S_DRAIN);

endmodule

// File: tb/tb_drive_mode_arbiter.sv
// Bench for drive_mode_arbiter: directed scenarios followed by random traffic,
// all compared each cycle against a behavioural model of the arbitration rules.
module tb_drive_mode_arbiter;

  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       power_btn, mode_req;
  logic [1:0] mode_sel;
  logic [3:0] man_mv, semi_mv, auto_mv;
  logic       manual_enable, semi_auto_enable, auto_enable;
  logic [3:0] mv_out;
  logic [1:0] active_mode;
  logic       busy, err;

  int checks   = 0;
  int failures = 0;

  // model state
  bit         m_on, m_drain, m_err, m_pprev, m_mprev, m_seen_low;
  int         m_left;
  logic [1:0] m_mode, m_pend;
  logic [3:0] m_mv;

  drive_mode_arbiter #(.SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst(rst), .power_btn(power_btn), .mode_req(mode_req),
    .mode_sel(mode_sel), .man_mv(man_mv), .semi_mv(semi_mv), .auto_mv(auto_mv),
    .manual_enable(manual_enable), .semi_auto_enable(semi_auto_enable),
    .auto_enable(auto_enable), .mv_out(mv_out), .active_mode(active_mode),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] clean(input logic [3:0] v);
    logic [3:0] r;
    r = v;
    if (v[3] && v[2]) r[3:2] = 2'b00;
    if (v[1] && v[0]) r[1:0] = 2'b00;
    return r;
  endfunction

  function automatic logic [3:0] pick(input logic [1:0] m);
    if (m == 2'd0) return man_mv;
    if (m == 2'd1) return semi_mv;
    return auto_mv;
  endfunction

  task automatic model_reset();
    m_on = 0; m_drain = 0; m_err = 0; m_pprev = 0; m_mprev = 0; m_seen_low = 0;
    m_left = 0; m_mode = 2'd0; m_pend = 2'd0; m_mv = 4'd0;
  endtask

  task automatic model_step();
    bit pe, me;
    pe = power_btn && !m_pprev && m_seen_low;
    me = mode_req && !m_mprev;
    m_err = 0;
    m_mv  = 4'd0;
    if (!m_on) begin
      if (pe) begin m_on = 1; m_drain = 0; m_mode = 2'd0; end
    end else if (pe) begin
      m_on = 0; m_drain = 0;
    end else if (m_drain) begin
      m_err = me;
      m_left--;
      if (m_left == 0) begin m_drain = 0; m_mode = m_pend; end
    end else if (me && mode_sel != 2'd3 && mode_sel != m_mode) begin
      m_pend = mode_sel; m_drain = 1; m_left = SETTLE;
    end else begin
      m_err = me && (mode_sel == 2'd3);
      m_mv  = clean(pick(m_mode));
    end
    if (!power_btn) m_seen_low = 1;
    m_pprev = power_btn;
    m_mprev = mode_req;
  endtask

  task automatic check_all();
    logic [2:0] en_exp;
    en_exp = (m_on && !m_drain) ? (3'b001 << m_mode) : 3'b000;
    check("enables", {5'd0, auto_enable, semi_auto_enable, manual_enable}, {5'd0, en_exp});
    check("mv_out", {4'd0, mv_out}, {4'd0, m_mv});
    check("active_mode", {6'd0, active_mode}, {6'd0, m_mode});
    check("busy", {7'd0, busy}, {7'd0, m_drain});
    check("err", {7'd0, err}, {7'd0, m_err});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Reset asserted a little after a rising edge; outputs must clear before the next one.
  task automatic rst_mid();
    @(posedge clk);
    model_step();
    #2 rst = 1'b0;
    model_reset();
    #1 check_all();
    check("rst_async_zero", {mv_out, busy, manual_enable, semi_auto_enable, auto_enable}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; power_btn = 0; mode_req = 0; mode_sel = 2'd0;
    man_mv = 4'd0; semi_mv = 4'd0; auto_mv = 4'd0;
    model_reset();
    #12 check_all();
    @(negedge clk);
    rst = 1'b1;
    cycles(2);

    // power on
    power_btn = 1; cycle();
    check("pwr_on_manual", {7'd0, manual_enable}, 8'd1);
    power_btn = 0; cycle();

    // manual motion and sanitising
    man_mv = 4'b1010; cycles(2);
    check("mv_1010", {4'd0, mv_out}, 8'h0A);
    man_mv = 4'b1100; cycles(2);
    check("mv_fb_cancel", {4'd0, mv_out}, 8'h00);
    man_mv = 4'b0011; cycles(2);
    man_mv = 4'b0101; semi_mv = 4'b1000; cycles(2);
    check("mv_semi_ignored", {4'd0, mv_out}, 8'h05);

    // change to auto
    mode_sel = 2'b10; mode_req = 1; cycle();
    mode_req = 0; cycles(SETTLE + 1);
    check("auto_granted", {7'd0, auto_enable}, 8'd1);

    // reserved request, then a change with a rejected request during drain
    mode_sel = 2'b11; mode_req = 1; cycle();
    check("err_reserved", {7'd0, err}, 8'd1);
    mode_req = 0; cycle();
    mode_sel = 2'b00; mode_req = 1; cycle();
    mode_req = 0; cycle();
    mode_sel = 2'b01; mode_req = 1; cycle();
    mode_req = 0; cycles(SETTLE);
    check("drain_target_kept", {6'd0, active_mode}, 8'd0);

    // same-mode request ignored
    mode_sel = 2'b00; mode_req = 1; cycle();
    mode_req = 0; cycle();

    // simultaneous power and mode edges
    mode_sel = 2'b01; mode_req = 1; power_btn = 1; cycle();
    check("pwr_prio_err", {7'd0, err}, 8'd0);
    mode_req = 0; power_btn = 0; cycles(2);

    // back on, into drain, reset in drain cycle 2 with button held
    power_btn = 1; cycle();
    power_btn = 0; cycle();
    mode_sel = 2'b10; mode_req = 1; cycle();
    mode_req = 0; power_btn = 1;
    rst_mid();
    cycles(3);
    check("held_btn_off", {7'd0, manual_enable}, 8'd0);
    power_btn = 0; cycle();
    power_btn = 1; cycle();
    power_btn = 0; cycle();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      power_btn = ($urandom_range(0, 19) == 0);
      mode_req  = ($urandom_range(0, 2) == 0);
      mode_sel  = 2'($urandom_range(0, 3));
      man_mv    = 4'($urandom);
      semi_mv   = 4'($urandom);
      auto_mv   = 4'($urandom);
      if ($urandom_range(0, 299) == 0) rst_mid();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
